// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential execute unit.
package alu_seq_pkg;

    // Widened 4-bit opcode space; 4'h8..4'hF are illegal.
    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        AND  = 4'h2,
        XOR  = 4'h3,
        LSH  = 4'h4,
        RSH  = 4'h5,
        LFSR = 4'h6,
        CMP  = 4'h7
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] OP_ILLEGAL_BASE = 4'h8;

    // Legacy 3-bit mnemonic encoding still used by the existing core.
    typedef enum logic [2:0] {
        MNE_ADD,
        MNE_SUB,
        MNE_AND,
        MNE_XOR,
        MNE_LSH,
        MNE_RSH,
        MNE_LFSR,
        MNE_CMP
    } op_mne;

endpackage

// File: rtl/alu_seq_if.sv
// Decode-side and writeback-side handshakes of the execute unit.
interface alu_seq_if #(
    parameter int W   = 8,
    parameter int OPW = 4
);
    logic           InValid;
    logic           InReady;
    logic [OPW-1:0] Op;
    logic [W-1:0]   InA;
    logic [W-1:0]   InB;
    logic           OutValid;
    logic           OutReady;
    logic [W-1:0]   Out;
    logic           Carry;
    logic           Zero;
    logic           Err;

    // Master: decode stage issuing ops and writeback consuming results.
    modport master (
        output InValid, Op, InA, InB, OutReady,
        input  InReady, OutValid, Out, Carry, Zero, Err
    );

    // Slave: the execute unit itself.
    modport slave (
        input  InValid, Op, InA, InB, OutReady,
        output InReady, OutValid, Out, Carry, Zero, Err
    );
endinterface

// File: rtl/alu_seq_step.sv
// One iteration of a multi-cycle op; res = {carry, next_state}.
module alu_seq_step
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  op_t          op,
    input  logic [W-1:0] state,
    input  logic [W-1:0] taps,
    output logic [W:0]   res
);

    // Shift by one bit (carry = bit shifted out) or advance the LFSR once.
    always_comb begin
        res = {1'b0, state};
        case (op)
            LSH:     res = {state[W-1], state[W-2:0], 1'b0};
            RSH:     res = {state[0], 1'b0, state[W-1:1]};
            LFSR:    res = {1'b0, state[W-2:0], ^(state & taps)};
            default: res = {1'b0, state};
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential execute unit: single-cycle ALU ops plus iterative shifts and LFSR.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W          = 8,
    parameter int OPW        = 4,
    parameter int LFSR_STEPS = 8
) (
    input logic     Clk,
    input logic     Reset,
    alu_seq_if.slave bus
);

    localparam int MAX_IT = (W > LFSR_STEPS) ? W : LFSR_STEPS;
    localparam int CW     = $clog2(MAX_IT + 1);

    localparam logic [W-1:0]  W_VAL    = W'(W);
    localparam logic [CW-1:0] CNT_W    = CW'(W);
    localparam logic [CW-1:0] CNT_LFSR = CW'(LFSR_STEPS);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  taps_q, taps_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    step_res;
    logic [W:0]    sum;

    assign sum = {1'b0, bus.InA} + {1'b0, bus.InB};

    alu_seq_step #(
        .W(W)
    ) u_step (
        .op   (op_q),
        .state(acc_q),
        .taps (taps_q),
        .res  (step_res)
    );

    // Next-state and datapath: compute at accept, iterate in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        taps_d  = taps_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.InValid) begin
                    op_d    = op_t'(bus.Op);
                    taps_d  = bus.InB;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                    if (bus.Op >= OPW'(OP_ILLEGAL_BASE)) begin
                        acc_d = '0;
                        err_d = 1'b1;
                    end else begin
                        case (op_t'(bus.Op))
                            ADD: begin
                                acc_d   = sum[W-1:0];
                                carry_d = sum[W];
                            end
                            SUB: begin
                                acc_d   = bus.InA - bus.InB;
                                carry_d = (bus.InA < bus.InB);
                            end
                            AND: acc_d = bus.InA & bus.InB;
                            XOR: acc_d = bus.InA ^ bus.InB;
                            CMP: acc_d = {{(W-1){1'b0}}, (bus.InA == bus.InB)};
                            LSH, RSH: begin
                                acc_d   = bus.InA;
                                // Amounts beyond the width behave like a full-width shift.
                                cnt_d   = (bus.InB >= W_VAL) ? CNT_W : CW'(bus.InB);
                                state_d = (cnt_d == '0) ? DONE : BUSY;
                            end
                            LFSR: begin
                                acc_d   = bus.InA;
                                cnt_d   = CNT_LFSR;
                                state_d = BUSY;
                            end
                            default: acc_d = '0;
                        endcase
                    end
                    zero_d = (acc_d == '0);
                end
            end
            BUSY: begin
                acc_d   = step_res[W-1:0];
                carry_d = step_res[W];
                zero_d  = (step_res[W-1:0] == '0);
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards any in-flight op.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q    <= ADD;
            acc_q   <= '0;
            taps_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            op_q    <= op_d;
            acc_q   <= acc_d;
            taps_q  <= taps_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InReady  = (state_q == IDLE);
    assign bus.OutValid = (state_q == DONE);
    assign bus.Out      = acc_q;
    assign bus.Carry    = carry_q;
    assign bus.Zero     = zero_q;
    assign bus.Err      = err_q;

endmodule
